// File: rtl/ins_decode_stage_if.sv
// Handshake bundle for the decode stage: upstream instruction in, decoded result out.
interface ins_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;

    logic            out_valid;
    logic            out_ready;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_we;
    logic [XLEN-1:0] pc_out;

    modport slave (
        input  in_valid, ins, pc, out_ready,
        output in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7,
               imm, fmt, rd_we, pc_out
    );

    modport master (
        output in_valid, ins, pc, out_ready,
        input  in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7,
               imm, fmt, rd_we, pc_out
    );
endinterface

// File: rtl/ins_decode_stage.sv
// Registered RV32/RV64 instruction decode stage with a 2-entry skid buffer.
// Decode is done on the input side so both OUT and SKID hold decoded entries.
module ins_decode_stage #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ILLEGAL_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    ins_decode_stage_if.slave     bus
);

    localparam int unsigned INS_W = 32;
    localparam int unsigned FMT_W = 3;

    localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
    localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_d;

    logic in_ready_q, out_valid_q;
    logic accept, drain;
    logic load_out_new, load_out_skid, load_skid;

    logic [INS_W-1:0] dec_ins;
    logic [FMT_W-1:0] dec_fmt;
    logic [INS_W-1:0] dec_imm32;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_rd_we;

    logic [INS_W-1:0] out_ins,   skid_ins;
    logic [XLEN-1:0]  out_pc,    skid_pc;
    logic [XLEN-1:0]  out_imm,   skid_imm;
    logic [FMT_W-1:0] out_fmt,   skid_fmt;
    logic             out_rd_we, skid_rd_we;

    assign dec_ins = bus.ins;
    assign accept  = bus.in_valid & in_ready_q;
    assign drain   = out_valid_q & bus.out_ready;

    // Format classification, immediate assembly and rd write enable
    always_comb begin
        dec_fmt   = (ILLEGAL_CHECK != 0) ? FMT_ILL : FMT_R;
        dec_imm32 = '0;
        dec_rd_we = 1'b0;

        if (dec_ins[1:0] == 2'b11) begin
            unique case (dec_ins[6:0])
                7'b0110011:                                     dec_fmt = FMT_R;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
                7'b0100011:                                     dec_fmt = FMT_S;
                7'b1100011:                                     dec_fmt = FMT_B;
                7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
                7'b1101111:                                     dec_fmt = FMT_J;
                default:                                        ;
            endcase
        end

        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{dec_ins[31]}}, dec_ins[31:20]};
            FMT_S: dec_imm32 = {{20{dec_ins[31]}}, dec_ins[31:25], dec_ins[11:7]};
            FMT_B: dec_imm32 = {{19{dec_ins[31]}}, dec_ins[31], dec_ins[7],
                                dec_ins[30:25], dec_ins[11:8], 1'b0};
            FMT_U: dec_imm32 = {dec_ins[31:12], 12'b0};
            FMT_J: dec_imm32 = {{11{dec_ins[31]}}, dec_ins[31], dec_ins[19:12],
                                dec_ins[20], dec_ins[30:21], 1'b0};
            default: dec_imm32 = '0;
        endcase

        case (dec_fmt)
            FMT_R, FMT_I, FMT_U, FMT_J: dec_rd_we = (dec_ins[11:7] != 5'd0);
            default:                    dec_rd_we = 1'b0;
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    // Next-state and load selection
    always_comb begin
        state_d       = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_out_new = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (drain) begin
                        state_d       = ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // OUT register: fresh decode or promoted SKID entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ins   <= '0;
            out_pc    <= '0;
            out_imm   <= '0;
            out_fmt   <= '0;
            out_rd_we <= 1'b0;
        end else if (load_out_new) begin
            out_ins   <= dec_ins;
            out_pc    <= bus.pc;
            out_imm   <= dec_imm;
            out_fmt   <= dec_fmt;
            out_rd_we <= dec_rd_we;
        end else if (load_out_skid) begin
            out_ins   <= skid_ins;
            out_pc    <= skid_pc;
            out_imm   <= skid_imm;
            out_fmt   <= skid_fmt;
            out_rd_we <= skid_rd_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ins   <= '0;
            skid_pc    <= '0;
            skid_imm   <= '0;
            skid_fmt   <= '0;
            skid_rd_we <= 1'b0;
        end else if (load_skid) begin
            skid_ins   <= dec_ins;
            skid_pc    <= bus.pc;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_rd_we <= dec_rd_we;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = out_ins[6:0];
    assign bus.rd        = out_ins[11:7];
    assign bus.funct3    = out_ins[14:12];
    assign bus.rs1       = out_ins[19:15];
    assign bus.rs2       = out_ins[24:20];
    assign bus.funct7    = out_ins[31:25];
    assign bus.imm       = out_imm;
    assign bus.fmt       = out_fmt;
    assign bus.rd_we     = out_rd_we;
    assign bus.pc_out    = out_pc;

endmodule

// File: doc/ins_decode_stage.md
# ins_decode_stage

Registered RV32/RV64 instruction-decode stage that replaces the purely combinational field split with a handshaked pipeline stage. It accepts a fetched instruction word and its PC, extracts the fields, classifies the instruction format, and produces the sign-extended immediate and a register-write enable. It sits between the fetch buffer and the register-file read / execute stage. A 2-entry skid buffer provides full throughput under backpressure.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. Sets the `pc` and `imm` widths.
- ILLEGAL_CHECK, 1. When 1, unknown opcodes are flagged illegal. When 0, they are decoded as R-type.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept an instruction; registered.
- ins  in  32  instruction word.
- pc  in  XLEN  instruction address.
- out_valid  out  1  decoded result is valid.
- out_ready  in  1  downstream accepts the result.
- opcode  out  7  ins[6:0].
- rd  out  5  ins[11:7].
- funct3  out  3  ins[14:12].
- rs1  out  5  ins[19:15].
- rs2  out  5  ins[24:20].
- funct7  out  7  ins[31:25].
- imm  out  XLEN  sign-extended immediate.
- fmt  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- rd_we  out  1  instruction writes rd.
- pc_out  out  XLEN  PC paired with the result.

## Operation
- Handshake: input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Storage: one output register (OUT) plus one skid register (SKID). Decode happens on the input side, so SKID holds already-decoded data.
- States: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
  - EMPTY + accept -> ONE.
  - ONE + accept & !drain -> FULL.
  - ONE + drain & !accept -> EMPTY.
  - ONE + accept & drain -> ONE; OUT is loaded with the new entry.
  - FULL + drain -> ONE; SKID moves to OUT.
- in_ready equals "not FULL next cycle" and is registered. It is 0 only in FULL.
- Format map (opcode):
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else, or ins[1:0] != 2'b11 -> 7 if ILLEGAL_CHECK, else R.
- Immediates, all sign-extended from ins[31] to XLEN:
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U: {ins[31:12], 12'b0}.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - R and illegal: 0.
- rd_we is 1 for R, I, U, J and 0 for S, B, illegal. It is forced to 0 when rd == 0.
- Raw fields (opcode..funct7) are always passed through unchanged, including for illegal instructions.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle while out_ready = 1.
- Reset (rst_n low, asynchronous):
  - out_valid = 0 and in_ready = 1.
  - All data outputs = 0, fmt = 0, rd_we = 0.
  - State = EMPTY, SKID invalid.
- Reset asserted mid-operation discards all held entries immediately; no partial output is produced.
- flush = 1 at a clock edge:
  - State -> EMPTY, so out_valid = 0 and in_ready = 1 next cycle.
  - Any same-cycle input transfer is dropped.
  - Any same-cycle output transfer still counts downstream.
- Backpressure: while out_valid & !out_ready, all OUT outputs hold stable.
- FULL + drain: in_ready rises the following cycle, so no input is accepted in the drain cycle itself.
- Ordering: strictly FIFO. SKID always drains before any newer entry.
- XLEN = 64: U immediate bits [63:32] replicate ins[31].

## Test plan
- Reset, then 0xFFF00093 at pc 0x100 -> next cycle: out_valid = 1, opcode 0x13, rd 1, fmt 1, imm 0xFFFFFFFF, rd_we 1, pc_out 0x100.
- Back-to-back 0x0020A423, 0xFE000EE3, 0x001000EF, 0x123452B7 with out_ready = 1 -> one result per cycle, in order:
  - fmt 2, imm 8, rd_we 0.
  - fmt 3, imm 0xFFFFFFFC.
  - fmt 5, imm 0x00000800, rd 1.
  - fmt 4, imm 0x12345000, rd 5.
- Hold out_ready = 0 and stream 3 instructions -> 2 accepted, in_ready = 0 from the cycle after the second accept. Raise out_ready -> both emerge in order, in_ready = 1 one cycle after the first drain, third instruction accepted.
- Instructions 0x00000000 and 0x0000007F with ILLEGAL_CHECK = 1 -> fmt 7, imm 0, rd_we 0. With ILLEGAL_CHECK = 0 -> fmt 0.
- In FULL state, assert flush together with in_valid -> next cycle out_valid = 0, in_ready = 1, and no stale or new entry ever appears.
- XLEN = 64 with 0x800000B7 (lui x1) -> imm 0xFFFFFFFF80000000. Assert rst_n low mid-stream -> out_valid drops to 0 asynchronously.
